// File: rtl/spi_bridge_pkg.sv
// Shared command codes, acknowledge bytes and FSM states for the SPI-to-RAM bridge.
package spi_bridge_pkg;

    localparam logic [7:0] CMD_ECHO  = 8'h11;
    localparam logic [7:0] CMD_WRITE = 8'h12;
    localparam logic [7:0] CMD_READ  = 8'h13;
    localparam logic [7:0] CMD_STAT  = 8'h14;
    localparam logic [7:0] CMD_ID    = 8'h15;

    localparam logic [7:0] ACK_ECHO  = 8'h22;
    localparam logic [7:0] ACK_WRITE = 8'h23;
    localparam logic [7:0] ACK_READ  = 8'h24;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ECHO,
        S_WADDR,
        S_WDATA,
        S_RADDR,
        S_RDATA,
        S_STAT,
        S_ID,
        S_ERR
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bridge_ram.sv
// Byte RAM with one write port and two independent registered read ports.
// No reset; a read of the address being written returns the old contents.
module bridge_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    input  logic [ADDR_W-1:0] faddr,
    output logic [7:0]        fdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
        fdata <= mem[faddr];
    end

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave byte framer: synchronises the SPI pins into clk,
// delivers one done pulse per received byte and shifts out the tx byte.
module spi_slave #(
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mselect,
    input  logic       mclk,
    input  logic       mosi,
    output logic       miso,
    output logic       sel,
    output logic       done,
    output logic [7:0] rx,
    input  logic [7:0] tx
);
    logic [1:0] ss_sync;
    logic [2:0] ck_sync;
    logic [1:0] mo_sync;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] shreg;
    logic       rise, fall, lead, trail, samp, shft, load;

    assign sel   = ~ss_sync[1];
    assign rise  = ck_sync[1] & ~ck_sync[2];
    assign fall  = ~ck_sync[1] & ck_sync[2];
    assign lead  = CPOL ? fall : rise;
    assign trail = CPOL ? rise : fall;
    assign samp  = CPHA ? trail : lead;
    assign shft  = CPHA ? lead : trail;
    // tx is captured at the first edge of every byte in both phases
    assign load  = (bit_cnt == 3'd0) && lead;
    // with CPHA=0 bit 7 must be on the wire before that first edge
    assign miso  = (!CPHA && bit_cnt == 3'd0) ? tx[7] : shreg[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync <= 2'b11;
            ck_sync <= {3{CPOL}};
            mo_sync <= 2'b00;
            bit_cnt <= 3'd0;
            rx_sh   <= 7'd0;
            rx      <= 8'd0;
            shreg   <= 8'hFF;
            done    <= 1'b0;
        end else begin
            ss_sync <= {ss_sync[0], mselect};
            ck_sync <= {ck_sync[1:0], mclk};
            mo_sync <= {mo_sync[0], mosi};
            done    <= 1'b0;
            if (!sel) begin
                bit_cnt <= 3'd0;
            end else begin
                if (samp) begin
                    rx_sh   <= {rx_sh[5:0], mo_sync[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done <= 1'b1;
                        rx   <= {rx_sh, mo_sync[1]};
                    end
                end
                if (load)
                    shreg <= tx;
                else if (shft)
                    shreg <= {shreg[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI-slave command engine: echo, burst write/read, status and ID access to an
// on-chip byte RAM, plus a fabric-side read port onto the same RAM.
module spi_ram_bridge
    import spi_bridge_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          ADDR_BYTES = (ADDR_W + 7) / 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter logic [7:0]  ID_BYTE    = 8'hA5,
    parameter logic [7:0]  UDF        = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mselect,
    input  logic              mclk,
    input  logic              mosi,
    output logic              miso,
    output logic              err,
    output logic              busy,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata
);
    localparam logic [1:0] LAST_AB = 2'(ADDR_BYTES - 1);

    state_t            state;
    logic [7:0]        tx, rx, err_count;
    logic [ADDR_W-1:0] ptr, acc, acc_next, ram_raddr;
    logic [1:0]        abyte;
    logic              sel, done, rd_pend, loc_vld, ram_we;
    logic [7:0]        ram_rdata, loc_fdata;

    spi_slave #(.CPOL(CPOL), .CPHA(CPHA)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .mselect (mselect),
        .mclk    (mclk),
        .mosi    (mosi),
        .miso    (miso),
        .sel     (sel),
        .done    (done),
        .rx      (rx),
        .tx      (tx)
    );

    // Address bytes arrive MSB first; bits above ADDR_W fall off the top.
    assign acc_next  = (acc << 8) | ADDR_W'(rx);
    assign ram_we    = sel && done && (state == S_WDATA);
    assign ram_raddr = (state == S_RADDR) ? acc_next : ptr;

    bridge_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ptr),
        .wdata (rx),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .faddr (loc_addr),
        .fdata (loc_fdata)
    );

    // RAM has no reset, so the fabric port reads as zero until its first update.
    assign loc_rdata = loc_vld ? loc_fdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tx        <= UDF;
            ptr       <= '0;
            acc       <= '0;
            abyte     <= 2'd0;
            err_count <= 8'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rd_pend   <= 1'b0;
            loc_vld   <= 1'b0;
        end else begin
            loc_vld <= 1'b1;
            busy    <= sel;
            rd_pend <= 1'b0;
            if (!sel) begin
                state <= S_IDLE;
                tx    <= UDF;
                abyte <= 2'd0;
                err   <= 1'b0;
            end else if (rd_pend) begin
                // read data for the address issued on the previous cycle
                tx  <= ram_rdata;
                ptr <= ptr + 1'b1;
            end else if (done) begin
                case (state)
                    S_IDLE: begin
                        case (rx)
                            CMD_ECHO:  begin state <= S_ECHO;  tx <= ACK_ECHO;  end
                            CMD_WRITE: begin state <= S_WADDR; tx <= ACK_WRITE; end
                            CMD_READ:  begin state <= S_RADDR; tx <= ACK_READ;  end
                            CMD_STAT:  begin state <= S_STAT;  tx <= err_count; end
                            CMD_ID:    begin state <= S_ID;    tx <= ID_BYTE;   end
                            default: begin
                                state     <= S_ERR;
                                tx        <= UDF;
                                err       <= 1'b1;
                                err_count <= sat_inc(err_count);
                            end
                        endcase
                    end
                    S_ECHO: tx <= rx;
                    S_WADDR, S_RADDR: begin
                        tx  <= UDF;
                        acc <= acc_next;
                        if (abyte == LAST_AB) begin
                            abyte <= 2'd0;
                            ptr   <= acc_next;
                            if (state == S_RADDR) begin
                                state   <= S_RDATA;
                                rd_pend <= 1'b1;
                            end else begin
                                state <= S_WDATA;
                            end
                        end else begin
                            abyte <= abyte + 2'd1;
                        end
                    end
                    S_WDATA: begin
                        tx  <= UDF;
                        ptr <= ptr + 1'b1;
                    end
                    S_RDATA: rd_pend <= 1'b1;
                    S_STAT:  tx <= err_count;
                    S_ID:    tx <= ID_BYTE;
                    S_ERR: begin
                        tx  <= 8'hFF;
                        err <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= UDF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench: the SPI driver queues the expected miso byte for every byte
// it sends; a monitor rebuilds miso bytes on mclk and checks them in order.
module tb_spi_ram_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ms8 = 1'b1;
    logic       ms10 = 1'b1;
    logic       use10 = 1'b0;
    logic       chk_en = 1'b1;
    logic [7:0] la8 = 8'h00;
    logic [9:0] la10 = 10'h000;
    wire        miso8, err8, busy8, miso10, err10, busy10;
    wire  [7:0] lr8, lr10;
    wire        cs_n   = use10 ? ms10 : ms8;
    wire        miso_m = use10 ? miso10 : miso8;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] expq [$];

    always #5 clk = ~clk;

    spi_ram_bridge #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mselect(ms8), .mclk(mclk), .mosi(mosi),
        .miso(miso8), .err(err8), .busy(busy8), .loc_addr(la8), .loc_rdata(lr8)
    );

    spi_ram_bridge #(.ADDR_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .mselect(ms10), .mclk(mclk), .mosi(mosi),
        .miso(miso10), .err(err10), .busy(busy10), .loc_addr(la10), .loc_rdata(lr10)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic fbegin();
        if (use10) ms10 = 1'b0;
        else ms8 = 1'b0;
        #40;
    endtask

    task automatic fend();
        #40;
        ms8  = 1'b1;
        ms10 = 1'b1;
        #100;
    endtask

    task automatic bits(input logic [7:0] mo, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = mo[i];
            #40 mclk = 1'b1;
            #40 mclk = 1'b0;
        end
    endtask

    task automatic sbyte(input logic [7:0] mo, input logic [7:0] ex);
        expq.push_back(ex);
        bits(mo, 8);
    endtask

    // bytes are packed MSB-first: the first byte on the wire is the leftmost
    task automatic frame(input int n, input logic [63:0] mo, input logic [63:0] ex);
        fbegin();
        for (int i = 0; i < n; i++)
            sbyte(mo[8*(n-1-i) +: 8], ex[8*(n-1-i) +: 8]);
        fend();
    endtask

    initial begin
        int         nb = 0;
        int         cnt = 0;
        logic [7:0] sh = 8'h00;
        logic [7:0] e;
        forever begin
            @(posedge mclk or posedge cs_n);
            if (cs_n) begin
                cnt = 0;
            end else begin
                sh = {sh[6:0], miso_m};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (chk_en) begin
                        if (expq.size() == 0) begin
                            n_chk++;
                            $display("FAIL miso_b%0d: got 0x%0h with nothing expected", nb, sh);
                        end else begin
                            e = expq.pop_front();
                            chk($sformatf("miso_b%0d", nb), 32'(sh), 32'(e));
                        end
                        nb++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        #25;
        chk("rst_miso8",  32'(miso8), 32'd1);
        chk("rst_err8",   32'(err8),  32'd0);
        chk("rst_busy8",  32'(busy8), 32'd0);
        chk("rst_loc8",   32'(lr8),   32'd0);
        chk("rst_loc10",  32'(lr10),  32'd0);
        rst_n = 1'b1;
        #50;

        // ADDR_W=8: echo, write burst, read burst with no dummy byte
        frame(3, 64'h11_5A_C3,       64'hFF_22_5A);
        frame(5, 64'h12_10_01_02_03, 64'hFF_23_FF_FF_FF);
        frame(5, 64'h13_10_00_00_00, 64'hFF_24_01_02_03);
        @(negedge clk); la8 = 8'h11;
        @(negedge clk); chk("loc8_11", 32'(lr8), 32'h02);
        la8 = 8'h12;
        @(negedge clk); chk("loc8_12", 32'(lr8), 32'h03);

        // bad command: err high inside the frame, low after deselect
        fbegin();
        sbyte(8'h7E, 8'hFF);
        #60;
        chk("err_in_frame",  32'(err8),  32'd1);
        chk("busy_in_frame", 32'(busy8), 32'd1);
        sbyte(8'h00, 8'hFF);
        fend();
        chk("err_after", 32'(err8),  32'd0);
        chk("busy_after", 32'(busy8), 32'd0);
        frame(2, 64'h14_00, 64'hFF_01);

        // 300 more bad frames saturate err_count at 0xFF
        for (int i = 0; i < 300; i++)
            frame(1, 64'h7E, 64'hFF);
        frame(3, 64'h14_00_00, 64'hFF_FF_FF);
        frame(3, 64'h15_00_00, 64'hFF_A5_A5);

        // ADDR_W=10, two address bytes, pointer wraps 0x3FF -> 0x000
        use10 = 1'b1;
        frame(5, 64'h12_03_FF_AA_BB, 64'hFF_23_FF_FF_FF);
        @(negedge clk); la10 = 10'h3FF;
        @(negedge clk); chk("loc10_3ff", 32'(lr10), 32'hAA);
        la10 = 10'h000;
        @(negedge clk); chk("loc10_000", 32'(lr10), 32'hBB);
        frame(5, 64'h13_03_FF_00_00, 64'hFF_24_FF_AA_BB);

        // deselect after half an address: partial address must be dropped
        fbegin();
        sbyte(8'h12, 8'hFF);
        sbyte(8'h03, 8'h23);
        fend();
        frame(4, 64'h13_00_00_00, 64'hFF_24_FF_BB);
        la10 = 10'h3FF;
        @(negedge clk); @(negedge clk);
        chk("loc10_after_abort", 32'(lr10), 32'hAA);

        // reset in the middle of a read burst on the 8-bit bridge
        use10 = 1'b0;
        fbegin();
        sbyte(8'h13, 8'hFF);
        sbyte(8'h10, 8'h24);
        sbyte(8'h00, 8'h01);
        chk_en = 1'b0;
        bits(8'h00, 4);
        rst_n = 1'b0;
        #20;
        chk("midrst_err8",  32'(err8),  32'd0);
        chk("midrst_loc8",  32'(lr8),   32'd0);
        chk("midrst_miso8", 32'(miso8), 32'd1);
        #20 rst_n = 1'b1;
        bits(8'h00, 4);
        fend();
        chk_en = 1'b1;
        frame(2, 64'h14_00,          64'hFF_00);
        frame(5, 64'h13_10_00_00_00, 64'hFF_24_01_02_03);

        #200;
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
